// File: rtl/input_feed_controller.sv
// Input feed controller: loads host words into a ROWS-wide row memory,
// then streams columns out with a diagonally skewed per-row valid.
module input_feed_controller #(
  parameter int ROWS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic [7:0]      cols_m1,
  input  logic            host_valid,
  input  logic [15:0]     host_data,
  output logic            host_ready,
  input  logic            stream_en,
  input  logic            abort,
  output logic [9:0]      mem_addr,
  output logic [15:0]     mem_data,
  output logic            mem_write,
  output logic            mem_read,
  output logic            mem_rst,
  output logic [ROWS-1:0] row_valid,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    STREAM,
    DRAIN
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [9:0] wr_ptr;
  logic [7:0] rd_cnt;
  logic [7:0] cols;
  logic       accept;
  logic       rd_go;
  logic       start;
  logic       drain_end;

  always_comb begin
    state_n    = state;
    host_ready = (state == LOAD) && !abort;
    accept     = host_ready && host_valid;
    rd_go      = (state == STREAM) && stream_en && !abort;
    start      = (state == IDLE) && load_start && !abort;
    drain_end  = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_start) state_n = LOAD;
        end
        LOAD: begin
          if (accept && wr_ptr == {cols, 2'b11}) state_n = ARM;
        end
        ARM: begin
          state_n = STREAM;
        end
        STREAM: begin
          if (rd_go && rd_cnt == cols) state_n = DRAIN;
        end
        DRAIN: begin
          // last read has left mem_read and the lower rows: it sits in the top row
          if (!mem_read && row_valid[ROWS-2:0] == '0) begin
            state_n   = IDLE;
            drain_end = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_cnt    <= '0;
      cols      <= '0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_rst   <= 1'b0;
      row_valid <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      busy      <= (state_n != IDLE);
      mem_write <= accept;
      mem_read  <= rd_go;
      mem_rst   <= (state_n == ARM);
      done      <= drain_end;
      if (abort) row_valid <= '0;
      else row_valid <= {row_valid[ROWS-2:0], mem_read};
      if (accept) begin
        mem_addr <= wr_ptr;
        mem_data <= host_data;
        wr_ptr   <= wr_ptr + 10'd1;
      end
      if (rd_go) rd_cnt <= rd_cnt + 8'd1;
      if (start) begin
        cols   <= cols_m1;
        wr_ptr <= '0;
        rd_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_input_feed_controller.sv
// Directed self-checking bench for input_feed_controller.
// Each scenario task drives stimulus and checks its own results.
module tb_input_feed_controller;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic [7:0]  cols_m1;
  logic        host_valid;
  logic [15:0] host_data;
  logic        host_ready;
  logic        stream_en;
  logic        abort;
  logic [9:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_write;
  logic        mem_read;
  logic        mem_rst;
  logic [3:0]  row_valid;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  int n_wr, n_rd, n_done, n_rst, n_ovl;
  logic [9:0]  wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [3:0]  rv_hist[$];
  bit          done_hist[$];

  input_feed_controller dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .cols_m1    (cols_m1),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .stream_en  (stream_en),
    .abort      (abort),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rst    (mem_rst),
    .row_valid  (row_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_logs;
    n_wr = 0; n_rd = 0; n_done = 0; n_rst = 0; n_ovl = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    rv_hist.delete();
    done_hist.delete();
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (mem_write) begin
      n_wr++;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_data);
    end
    if (mem_read) n_rd++;
    if (done) n_done++;
    if (mem_rst) n_rst++;
    if (mem_write && mem_read) n_ovl++;
    rv_hist.push_back(row_valid);
    done_hist.push_back(done);
  endtask

  task automatic do_load(input logic [7:0] c, input bit tgl,
                         input int stop, output int got);
    int cyc;
    bit acc;
    load_start = 1'b1;
    cols_m1 = c;
    tick;
    load_start = 1'b0;
    got = 0;
    cyc = 0;
    while (got < stop && cyc < 3000) begin
      host_valid = tgl ? (cyc % 2 == 0) : 1'b1;
      host_data = 16'(got + 1);
      #1;
      acc = host_valid && host_ready;
      tick;
      if (acc) got++;
      cyc++;
    end
    host_valid = 1'b0;
    checks++;
    if (got !== stop) begin
      failures++;
      $display("FAIL load_timeout got=%0d required=%0d", got, stop);
    end
  endtask

  task automatic run_stream(input logic [15:0] pat, input int len);
    int i;
    stream_en = 1'b1;
    tick;
    i = 0;
    while (n_done == 0 && i < 600) begin
      stream_en = (i < len) ? pat[i] : 1'b1;
      tick;
      i++;
    end
    stream_en = 1'b1;
    checks++;
    if (n_done == 0) begin
      failures++;
      $display("FAIL stream_timeout done=0 required=1");
    end
  endtask

  function automatic int bad_writes(input int n);
    int b;
    b = 0;
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] !== 10'(i) || wr_data_q[i] !== 16'(i + 1)) b++;
    end
    return b;
  endfunction

  function automatic int first_rv;
    for (int i = 0; i < rv_hist.size(); i++)
      if (rv_hist[i] != 4'b0000) return i;
    return -1;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if ({mem_write, mem_read, mem_rst, row_valid, busy, done, host_ready,
         mem_addr, mem_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs wr=%b rd=%b rv=%b busy=%b addr=%h data=%h required=0",
               mem_write, mem_read, row_valid, busy, mem_addr, mem_data);
    end
    rst = 1'b0;
    load_start = 1'b1;
    cols_m1 = 8'd0;
    tick;
    load_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || host_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_start busy=%b ready=%b required=1,1",
               busy, host_ready);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort_idle busy=%b required=0", busy);
    end
  endtask

  task automatic test_single_col;
    int got, k, bad;
    logic [3:0] exp_rv;
    clear_logs;
    do_load(8'd0, 1'b0, 4, got);
    run_stream(16'h0, 0);
    checks++;
    if (n_wr !== 4 || bad_writes(4) !== 0) begin
      failures++;
      $display("FAIL single_writes count=%0d bad=%0d required=4,0", n_wr, bad_writes(4));
    end
    checks++;
    if (n_rst !== 1 || n_rd !== 1) begin
      failures++;
      $display("FAIL single_rst_read rst=%0d rd=%0d required=1,1", n_rst, n_rd);
    end
    k = first_rv();
    bad = 0;
    exp_rv = 4'b0001;
    for (int j = 0; j < 4; j++) begin
      if (k < 0 || k + j >= rv_hist.size() || rv_hist[k + j] !== exp_rv) bad++;
      exp_rv = exp_rv << 1;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL single_row_valid_skew bad=%0d first=%0d required=0", bad, k);
    end
    checks++;
    if (k < 0 || k + 4 >= done_hist.size() || done_hist[k + 4] !== 1'b1) begin
      failures++;
      $display("FAIL single_done_timing first=%0d hist=%0d required_done_at=%0d",
               k, done_hist.size(), k + 4);
    end
    tick;
    checks++;
    if (n_done !== 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done_pulse done=%0d busy=%b required=1,0", n_done, busy);
    end
  endtask

  task automatic test_toggle_host;
    int got, d, bad;
    clear_logs;
    do_load(8'd2, 1'b1, 12, got);
    run_stream(16'h0, 0);
    checks++;
    if (n_wr !== 12 || bad_writes(12) !== 0) begin
      failures++;
      $display("FAIL toggle_writes count=%0d bad=%0d required=12,0", n_wr, bad_writes(12));
    end
    checks++;
    if (n_rd !== 3) begin
      failures++;
      $display("FAIL toggle_reads rd=%0d required=3", n_rd);
    end
    d = done_hist.size() - 1;
    bad = 0;
    if (d < 4) bad = 9;
    else begin
      for (int j = 1; j <= 3; j++) if (rv_hist[d - j][3] !== 1'b1) bad++;
      if (rv_hist[d - 4][3] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL toggle_done_after_rv3 bad=%0d required=0", bad);
    end
    checks++;
    if (n_ovl !== 0) begin
      failures++;
      $display("FAIL toggle_overlap n=%0d required=0", n_ovl);
    end
  endtask

  task automatic test_stall;
    int got, k, bad;
    logic [5:0] exp_pat;
    clear_logs;
    do_load(8'd3, 1'b0, 16, got);
    run_stream(16'b110011, 6);
    checks++;
    if (n_rd !== 4) begin
      failures++;
      $display("FAIL stall_reads rd=%0d required=4", n_rd);
    end
    exp_pat = 6'b110011;
    k = first_rv();
    bad = 0;
    for (int j = 0; j < 6; j++)
      if (k < 0 || k + j >= rv_hist.size() || rv_hist[k + j][0] !== exp_pat[j]) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL stall_rv0_pattern bad=%0d first=%0d required=0", bad, k);
    end
    checks++;
    if (n_done !== 1) begin
      failures++;
      $display("FAIL stall_done done=%0d required=1", n_done);
    end
  endtask

  task automatic test_full_load;
    int got;
    clear_logs;
    do_load(8'd255, 1'b0, 1024, got);
    run_stream(16'h0, 0);
    tick;
    checks++;
    if (n_wr !== 1024 || bad_writes(1024) !== 0) begin
      failures++;
      $display("FAIL full_writes count=%0d bad=%0d required=1024,0", n_wr, bad_writes(1024));
    end
    checks++;
    if (wr_addr_q.size() == 0 || wr_addr_q[wr_addr_q.size() - 1] !== 10'd1023) begin
      failures++;
      $display("FAIL full_last_addr size=%0d required_last=1023", wr_addr_q.size());
    end
    checks++;
    if (n_rd !== 256 || n_done !== 1) begin
      failures++;
      $display("FAIL full_reads_done rd=%0d done=%0d required=256,1", n_rd, n_done);
    end
    checks++;
    if (n_ovl !== 0) begin
      failures++;
      $display("FAIL full_overlap n=%0d required=0", n_ovl);
    end
  endtask

  task automatic test_abort;
    int got;
    clear_logs;
    do_load(8'd3, 1'b0, 5, got);
    abort = 1'b1;
    host_valid = 1'b1;
    load_start = 1'b1;
    #1;
    checks++;
    if (host_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_ready_priority ready=%b required=0", host_ready);
    end
    tick;
    abort = 1'b0;
    host_valid = 1'b0;
    load_start = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_write !== 1'b0 || host_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle busy=%b wr=%b ready=%b required=0,0,0",
               busy, mem_write, host_ready);
    end
    tick;
    tick;
    tick;
    checks++;
    if (n_done !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done done=%0d busy=%b required=0,0", n_done, busy);
    end
    clear_logs;
    do_load(8'd0, 1'b0, 4, got);
    run_stream(16'h0, 0);
    checks++;
    if (wr_addr_q.size() == 0 || wr_addr_q[0] !== 10'd0 || bad_writes(4) !== 0) begin
      failures++;
      $display("FAIL abort_restart size=%0d bad=%0d required_first_addr=0",
               wr_addr_q.size(), bad_writes(4));
    end
  endtask

  task automatic test_async_reset;
    int got;
    clear_logs;
    do_load(8'd3, 1'b0, 16, got);
    stream_en = 1'b1;
    tick;
    tick;
    tick;
    checks++;
    if (mem_read !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre_stream rd=%b busy=%b required=1,1", mem_read, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_write, mem_read, mem_rst, row_valid, busy, done, host_ready,
         mem_addr, mem_data} !== '0) begin
      failures++;
      $display("FAIL arst_outputs rd=%b rv=%b busy=%b addr=%h data=%h required=0",
               mem_read, row_valid, busy, mem_addr, mem_data);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_logs;
    do_load(8'd1, 1'b0, 8, got);
    run_stream(16'h0, 0);
    checks++;
    if (n_wr !== 8 || bad_writes(8) !== 0 || n_rd !== 2 || n_done !== 1) begin
      failures++;
      $display("FAIL arst_recover wr=%0d rd=%0d done=%0d required=8,2,1",
               n_wr, n_rd, n_done);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    load_start = 1'b0;
    cols_m1 = 8'd0;
    host_valid = 1'b0;
    host_data = 16'h0;
    stream_en = 1'b1;
    abort = 1'b0;
    clear_logs;
    test_reset;
    test_single_col;
    test_toggle_host;
    test_stall;
    test_full_load;
    test_abort;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
